// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare direction predictor.
// Optional perf counters in the top are enabled by GSHARE_PERF_EN.
package gshare_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Saturating 2-bit counter step; never wraps at either end.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    if (taken) n = (c == CTR_ST)  ? CTR_ST  : ctr_t'(c + 2'd1);
    else       n = (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2^HIST_W two-bit counters, one combinational read
// port and one synchronous read-modify-write training port.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int HIST_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [HIST_W-1:0] rd_idx,
  output ctr_t              rd_ctr,
  input  logic              wr_en,
  input  logic [HIST_W-1:0] wr_idx,
  input  logic              wr_taken
);

  localparam int DEPTH = 1 << HIST_W;

  ctr_t [DEPTH-1:0] pht;

  // Read sees pre-edge contents, so a same-cycle write shows up next cycle.
  assign rd_ctr = pht[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_WNT;
    end else if (wr_en) begin
      pht[wr_idx] <= ctr_next(pht[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// GShare direction predictor: speculative GHR with checkpoint repair, PHT
// indexed by PC^GHR. Define GSHARE_PERF_EN to build the perf counters.
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int HIST_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              pred_en,
  input  logic [31:0]       pred_pc,
  output logic              gshare_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispred,
  output logic [31:0]       perf_pred,
  output logic [31:0]       perf_miss
);

  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] pred_idx;
  logic [HIST_W-1:0] upd_idx;
  ctr_t              rd_ctr;
  logic              repair;
  logic              spec_shift;

  assign pred_idx     = pred_pc[HIST_W-1:0] ^ ghr;
  assign upd_idx      = upd_pc[HIST_W-1:0] ^ upd_hist;
  assign gshare_taken = pred_en & rd_ctr[1];
  assign pred_hist    = ghr;

  // Repair squashes the ID branch, so its speculative shift is discarded.
  assign repair     = upd_en & upd_mispred;
  assign spec_shift = pred_en & ~stall & ~repair;

  gshare_pht #(.HIST_W(HIST_W)) u_pht (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (pred_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (upd_en),
    .wr_idx   (upd_idx),
    .wr_taken (upd_taken)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           ghr <= '0;
    else if (repair)     ghr <= {upd_hist[HIST_W-2:0], upd_taken};
    else if (spec_shift) ghr <= {ghr[HIST_W-2:0], gshare_taken};
  end

`ifdef GSHARE_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_pred <= '0;
      perf_miss <= '0;
    end else begin
      if (spec_shift) perf_pred <= perf_pred + 32'd1;
      if (repair)     perf_miss <= perf_miss + 32'd1;
    end
  end
`else
  assign perf_pred = '0;
  assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed scoreboard bench for gshare_predictor; expected values are
// queued when stimulus is driven and popped when outputs are sampled.
module tb_gshare_predictor;

  localparam int HIST_W = 8;
`ifdef GSHARE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              stall, pred_en, upd_en, upd_taken, upd_mispred;
  logic [31:0]       pred_pc, upd_pc;
  logic [HIST_W-1:0] upd_hist;
  logic              gshare_taken;
  logic [HIST_W-1:0] pred_hist;
  logic [31:0]       perf_pred, perf_miss;

  gshare_predictor #(.HIST_W(HIST_W)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .pred_en(pred_en), .pred_pc(pred_pc),
    .gshare_taken(gshare_taken), .pred_hist(pred_hist),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .perf_pred(perf_pred), .perf_miss(perf_miss)
  );

  always #5 clock = ~clock;

  typedef enum logic [1:0] {S_TAKEN, S_HIST, S_PPRED, S_PMISS} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } item_t;

  item_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic push(input string tag, input sel_t sel, input logic [31:0] exp);
    item_t it;
    it.tag = tag; it.sel = sel; it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic exp_th(input string tag, input logic t, input logic [7:0] h);
    push({tag, ".taken"}, S_TAKEN, {31'd0, t});
    push({tag, ".hist"},  S_HIST,  {24'd0, h});
  endtask

  task automatic exp_perf(input string tag, input int np, input int nm);
    push({tag, ".perf_pred"}, S_PPRED, PERF ? np : 0);
    push({tag, ".perf_miss"}, S_PMISS, PERF ? nm : 0);
  endtask

  task automatic sample();
    item_t       it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.sel)
        S_TAKEN: obs = {31'd0, gshare_taken};
        S_HIST:  obs = {24'd0, pred_hist};
        S_PPRED: obs = perf_pred;
        default: obs = perf_miss;
      endcase
      n_cmp++;
      assert (obs === it.exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 0; pred_en = 0; pred_pc = 0;
    upd_en = 0; upd_pc = 0; upd_hist = 0; upd_taken = 0; upd_mispred = 0;
    exp_th("reset", 1'b0, 8'h00); exp_perf("reset", 0, 0);
    #2 sample();
    tick(); tick();
    reset = 1'b0;

    // 1: cold lookup predicts not-taken and shifts a 0
    pred_en = 1; pred_pc = 32'h10;
    exp_th("t1.lookup", 1'b0, 8'h00);
    #2 sample();
    tick();
    pred_en = 0;
    push("t1.ghr", S_HIST, 32'h00); exp_perf("t1", 1, 0);
    #2 sample();

    // 2: train entry 0x10 twice while stalled, then predict taken
    pred_en = 1; stall = 1; upd_en = 1; upd_pc = 32'h10; upd_hist = 8'h00; upd_taken = 1;
    push("t2.c01", S_TAKEN, 32'd0);
    #2 sample();
    tick();
    push("t2.c10", S_TAKEN, 32'd1);
    #2 sample();
    tick();
    upd_en = 0; stall = 0;
    exp_th("t2.c11", 1'b1, 8'h00);
    #2 sample();
    tick();
    pred_en = 0;
    push("t2.ghr", S_HIST, 32'h01); exp_perf("t2", 2, 0);
    #2 sample();

    // 3: repair to 0x5A, then repair wins over a same-cycle shift
    upd_en = 1; upd_mispred = 1; upd_pc = 32'h0; upd_hist = 8'h2D; upd_taken = 0;
    tick();
    upd_hist = 8'h33; upd_taken = 1; pred_en = 1; pred_pc = 32'h0;
    push("t3.ghr5a", S_HIST, 32'h5A); push("t3.miss1", S_PMISS, PERF ? 1 : 0);
    #2 sample();
    tick();
    upd_en = 0; upd_mispred = 0; pred_en = 0;
    push("t3.ghr67", S_HIST, 32'h67); exp_perf("t3", 2, 2);
    #2 sample();

    // 4: saturation on index 0x40 (pred_pc 0x27 ^ ghr 0x67)
    stall = 1; pred_en = 1; pred_pc = 32'h27;
    upd_en = 1; upd_pc = 32'h40; upd_hist = 8'h00; upd_taken = 1;
    push("t4.init", S_TAKEN, 32'd0);
    #2 sample();
    for (int i = 0; i < 5; i++) begin
      tick();
      push($sformatf("t4.up%0d", i), S_TAKEN, 32'd1);
      #2 sample();
    end
    upd_taken = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      push($sformatf("t4.dn%0d", i), S_TAKEN, (i == 0) ? 32'd1 : 32'd0);
      #2 sample();
    end
    upd_taken = 1;
    tick();
    push("t4.from00", S_TAKEN, 32'd0);
    #2 sample();
    tick();
    upd_en = 0;
    exp_th("t4.to10", 1'b1, 8'h67);
    #2 sample();

    // 5: stall freezes history and perf; release gives one shift
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_th($sformatf("t5.stall%0d", i), 1'b1, 8'h67);
      push($sformatf("t5.stall%0d.perf_pred", i), S_PPRED, PERF ? 2 : 0);
      #2 sample();
    end
    stall = 0;
    tick();
    pred_en = 0;
    push("t5.shift", S_HIST, 32'hCF); exp_perf("t5", 3, 2);
    #2 sample();
    tick();
    push("t5.hold", S_HIST, 32'hCF);
    #2 sample();

    // 6: same-cycle read/write of entry 0x80 returns the old value
    stall = 1; pred_en = 1; pred_pc = 32'h4F;
    upd_en = 1; upd_pc = 32'h80; upd_hist = 8'h00; upd_taken = 1;
    push("t6.old", S_TAKEN, 32'd0);
    #2 sample();
    tick();
    upd_en = 0;
    push("t6.new", S_TAKEN, 32'd1);
    #2 sample();
    pred_pc = 32'hDF;
    push("t6.e10", S_TAKEN, 32'd1);
    #1 sample();

    // asynchronous reset mid-cycle, with a training write that must be dropped
    tick();
    stall = 0; pred_pc = 32'h10;
    upd_en = 1; upd_pc = 32'h10; upd_hist = 8'h00; upd_taken = 1;
    #1 reset = 1'b1;
    exp_th("t6.rst", 1'b0, 8'h00); exp_perf("t6.rst", 0, 0);
    #2 sample();
    tick(); tick();
    reset = 1'b0; upd_en = 0; stall = 1;
    exp_th("t6.post10", 1'b0, 8'h00);
    #2 sample();
    pred_pc = 32'h80;
    push("t6.post80", S_TAKEN, 32'd0);
    #1 sample();
    pred_pc = 32'h40;
    push("t6.post40", S_TAKEN, 32'd0);
    #1 sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

GShare conditional-branch direction predictor that sits beside the front end. The IF stage consumes its `gshare_taken` when choosing the next PC. The ID stage drives the lookup with the decoded branch PC, and the EX stage's branch unit trains and repairs it. A global history register (GHR) is XORed with low PC bits to index a table of 2-bit saturating counters. The GHR is updated speculatively at prediction time and restored from a checkpoint on misprediction.

## Interface
Parameters:
- `HIST_W`, 8: GHR width; the pattern table has 2^HIST_W entries.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: pipeline stall; freezes the GHR.
- `pred_en`  in  1: ID holds a conditional branch.
- `pred_pc`  in  32: PC of that branch.
- `gshare_taken`  out  1: predict taken (combinational).
- `pred_hist`  out  HIST_W: GHR snapshot used for this lookup; carried down the pipe with the branch.
- `upd_en`  in  1: EX resolved a conditional branch this cycle.
- `upd_pc`  in  32: PC of the resolved branch.
- `upd_hist`  in  HIST_W: `pred_hist` captured when that branch was predicted.
- `upd_taken`  in  1: actual direction.
- `upd_mispred`  in  1: prediction was wrong (same source as `pred_failed`); qualified by `upd_en`.
- `perf_pred`  out  32: predictions counted.
- `perf_miss`  out  32: mispredictions counted.

## Operation
- Lookup index: `pred_pc[HIST_W-1:0] ^ ghr`.
- `gshare_taken = pred_en & pht[index][1]`.
- `pred_hist = ghr` at all times.
- Update index: `upd_pc[HIST_W-1:0] ^ upd_hist`.
- Counter update on `upd_en`: taken increments, not-taken decrements.
  - Saturates at 2'b11 and 2'b00; never wraps.
- Speculative history: when `pred_en & ~stall` and there is no repair, `ghr <= {ghr[HIST_W-2:0], gshare_taken}`.
- Repair: when `upd_en & upd_mispred`, `ghr <= {upd_hist[HIST_W-2:0], upd_taken}`.
  - Repair has priority over a same-cycle speculative shift, because that ID instruction is being squashed.
- `stall` never blocks training or repair.
- Priority of repair over `gshare_taken` is enforced in IF; this block does not mask `gshare_taken`.

## Timing
- Lookup is zero-latency combinational from `pred_pc` and `ghr` to `gshare_taken`.
- The GHR and PHT update on the rising `clock` edge.
- A same-cycle read and write of one PHT entry returns the old value; the new value is visible next cycle.
- Reset state (asynchronous, takes effect mid-operation too):
  - every PHT entry = 2'b01 (weakly not-taken);
  - `ghr` = 0, so `pred_hist` = 0;
  - `gshare_taken` = 0 while `pred_en` = 0;
  - `perf_pred` = 0 and `perf_miss` = 0.
- Updates arriving during reset are dropped.

## Configuration
- `GSHARE_PERF_EN` defined:
  - `perf_pred` increments on `pred_en & ~stall` with no repair;
  - `perf_miss` increments on `upd_en & upd_mispred`;
  - both are 32-bit wrapping counters.
- `GSHARE_PERF_EN` undefined: ports remain, tied to 0; no counter flops are generated.

## Structure
- The shared package `gshare_pkg` holds:
  - `ctr_t` (2-bit counter type);
  - constants `CTR_SNT`=2'b00, `CTR_WNT`=2'b01, `CTR_WT`=2'b10, `CTR_ST`=2'b11;
  - function `ctr_next(ctr_t, logic taken)` for the saturating update.
- Sub-module `gshare_pht`:
  - 2^HIST_W x 2 flop array with async reset;
  - one combinational read port and one synchronous write port;
  - instantiated once.
- The GHR, repair logic and perf counters live in the top module.

## Test plan
1. Reset, then `pred_en`=1, `pred_pc`=0x10 → `gshare_taken`=0, `pred_hist`=0x00. Next cycle GHR is still 0x00.
2. Two updates with `upd_pc`=0x10, `upd_hist`=0x00, `upd_taken`=1 → entry 0x10 goes 01→10→11. Then lookup `pred_pc`=0x10 with GHR=0 → `gshare_taken`=1, and next GHR=0x01.
3. GHR=0x5A; `upd_en`=1, `upd_mispred`=1, `upd_hist`=0x33, `upd_taken`=1, with `pred_en`=1 in the same cycle → next GHR=0x67 (repair wins). `perf_miss` increments by 1 when the macro is defined.
4. Saturation: 5 taken updates to one index → stays 2'b11. Then 5 not-taken updates → stays 2'b00; no wrap.
5. `pred_en`=1, `stall`=1 for 3 cycles → GHR unchanged, `gshare_taken` stable, `perf_pred` unchanged. Releasing `stall` → exactly one shift.
6. Same-cycle lookup and update of one entry at 2'b01 (update taken) → `gshare_taken`=0 that cycle and 1 the next. Asserting `reset` mid-sequence → all entries 01, GHR 0, counters 0, asynchronously.
